// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 control unit: opcode and ALU function
// codes, the sequencer state encoding and the packed control-word layout
// handed from the decoder to the top level.
package mu0_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] ALU_PASSY = 2'b00;
    localparam logic [1:0] ALU_ADD   = 2'b01;
    localparam logic [1:0] ALU_INC   = 2'b10;
    localparam logic [1:0] ALU_SUB   = 2'b11;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_e;

    typedef struct packed {
        logic       x_sel;
        logic       y_sel;
        logic       addr_sel;
        logic       pc_en;
        logic       ir_en;
        logic       acc_en;
        logic       rd;
        logic       wr;
        logic [1:0] alu_fs;
        logic       fetch;
        logic       halted;
    } ctrl_t;

    // Opcodes 0-3 touch memory in EXEC and therefore wait for Ready.
    function automatic logic is_mem_op(input logic [3:0] f);
        return (f[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/mu0_decode.sv
// Combinational decode for the MU0 sequencer.
//
// State table:
//   state | meaning
//   FETCH | read instruction at PC into IR, PC <= PC + 1
//   EXEC  | execute the opcode held in IR (memory ops wait for go)
//   HALT  | stopped after STP, only reset leaves
//
// Ports:
//   state_i   current sequencer state
//   f_i       opcode field IR[15:12]
//   n_i, z_i  ACC negative / zero flags
//   go_i      memory access completes this cycle
//   ctrl_o    control word (enables, strobes, selects, ALU function, status)
//   state_d_o next state
module mu0_decode
    import mu0_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] f_i,
    input  logic       n_i,
    input  logic       z_i,
    input  logic       go_i,
    output ctrl_t      ctrl_o,
    output state_e     state_d_o
);

    logic jump_taken;

    always_comb begin
        jump_taken = 1'b0;
        case (f_i)
            OP_JMP:  jump_taken = 1'b1;
            OP_JGE:  jump_taken = ~n_i;
            OP_JNE:  jump_taken = ~z_i;
            default: jump_taken = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d_o = state_i;
        case (state_i)
            FETCH: state_d_o = go_i ? EXEC : FETCH;
            EXEC: begin
                if (is_mem_op(f_i))
                    state_d_o = go_i ? FETCH : EXEC;
                else if (f_i == OP_STP)
                    state_d_o = HALT;
                else
                    state_d_o = FETCH;
            end
            HALT:    state_d_o = HALT;
            default: state_d_o = FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.fetch    = 1'b1;
                ctrl_o.rd       = 1'b1;
                ctrl_o.x_sel    = 1'b1;
                ctrl_o.alu_fs   = ALU_INC;
                ctrl_o.ir_en    = go_i;
                ctrl_o.pc_en    = go_i;
            end
            EXEC: begin
                case (f_i)
                    OP_LDA: begin
                        ctrl_o.addr_sel = 1'b1;
                        ctrl_o.rd       = 1'b1;
                        ctrl_o.alu_fs   = ALU_PASSY;
                        ctrl_o.acc_en   = go_i;
                    end
                    OP_STA: begin
                        ctrl_o.addr_sel = 1'b1;
                        ctrl_o.wr       = 1'b1;
                    end
                    OP_ADD: begin
                        ctrl_o.addr_sel = 1'b1;
                        ctrl_o.rd       = 1'b1;
                        ctrl_o.alu_fs   = ALU_ADD;
                        ctrl_o.acc_en   = go_i;
                    end
                    OP_SUB: begin
                        ctrl_o.addr_sel = 1'b1;
                        ctrl_o.rd       = 1'b1;
                        ctrl_o.alu_fs   = ALU_SUB;
                        ctrl_o.acc_en   = go_i;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        if (jump_taken) begin
                            ctrl_o.y_sel  = 1'b1;
                            ctrl_o.alu_fs = ALU_PASSY;
                            ctrl_o.pc_en  = 1'b1;
                        end
                    end
                    default: ctrl_o = '0;
                endcase
            end
            HALT:    ctrl_o.halted = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 instruction-sequencing control unit.
// Holds the sequencer state register; all outputs are decoded
// combinationally by mu0_decode. While Reset is low, register enables and
// memory strobes are forced off so an access in flight is abandoned at once.
//
// Ports:
//   Clk, Reset          clock (rising edge) and async active-low reset
//   F, N, Z             opcode field and ACC flags
//   Ready               memory access complete (ignored when USE_RDY = 0)
//   X_sel, Y_sel        ALU operand selects
//   Addr_sel            memory address select
//   PC_En, IR_En, Acc_En register load enables
//   Rd, Wr              memory strobes
//   ALU_Fs              ALU function code
//   Fetch, Halted       state status
module mu0_control
    import mu0_pkg::*;
#(
    parameter bit USE_RDY = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       Ready,
    output logic       X_sel,
    output logic       Y_sel,
    output logic       Addr_sel,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Acc_En,
    output logic       Rd,
    output logic       Wr,
    output logic [1:0] ALU_Fs,
    output logic       Fetch,
    output logic       Halted
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    logic   go;

    assign go = USE_RDY ? Ready : 1'b1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    mu0_decode u_decode (
        .state_i   (state_q),
        .f_i       (F),
        .n_i       (N),
        .z_i       (Z),
        .go_i      (go),
        .ctrl_o    (ctrl),
        .state_d_o (state_d)
    );

    assign X_sel    = ctrl.x_sel;
    assign Y_sel    = ctrl.y_sel;
    assign Addr_sel = ctrl.addr_sel;
    assign ALU_Fs   = ctrl.alu_fs;
    assign Fetch    = ctrl.fetch;
    assign Halted   = ctrl.halted;

    // Reset acts on the live outputs, not just the state register.
    assign PC_En    = ctrl.pc_en  & Reset;
    assign IR_En    = ctrl.ir_en  & Reset;
    assign Acc_En   = ctrl.acc_en & Reset;
    assign Rd       = ctrl.rd     & Reset;
    assign Wr       = ctrl.wr     & Reset;

endmodule

// File: tb/tb_mu0_control.sv
module tb_mu0_control;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] F;
    logic       N, Z, Ready;
    logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr;
    logic [1:0] ALU_Fs;
    logic       Fetch, Halted;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference phase of the instruction cycle
    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_HALT  = 2;
    int m_ph;

    mu0_control #(.USE_RDY(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Ready(Ready),
        .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel),
        .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En),
        .Rd(Rd), .Wr(Wr), .ALU_Fs(ALU_Fs), .Fetch(Fetch), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    wire [12:0] obs = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En,
                       Rd, Wr, ALU_Fs, Fetch, Halted};

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: observed %b expected %b (X Y A PC IR ACC Rd Wr Fs Fe H)",
                     tag, got, want);
        end
    endtask

    // Expected control word from the instruction semantics.
    function automatic logic [12:0] expect_out(int ph, logic [3:0] f, logic n, logic z,
                                                logic rdy, logic rst);
        logic xs, ys, as, pc, ir, acc, rd, wr, fe, ha;
        logic [1:0] fs;
        bit reads, writes, jumps;
        {xs, ys, as, pc, ir, acc, rd, wr, fe, ha} = '0;
        fs = 2'b00;
        reads  = (f == 0) || (f == 2) || (f == 3);
        writes = (f == 1);
        jumps  = (f == 4) || (f == 5 && !n) || (f == 6 && !z);
        if (ph == PH_FETCH) begin
            fe = 1; rd = 1; xs = 1; fs = 2'b10; ir = rdy; pc = rdy;
        end else if (ph == PH_EXEC) begin
            if (reads) begin
                as = 1; rd = 1; acc = rdy;
                fs = (f == 0) ? 2'b00 : (f == 2) ? 2'b01 : 2'b11;
            end else if (writes) begin
                as = 1; wr = 1;
            end else if (jumps) begin
                ys = 1; pc = 1;
            end
        end else begin
            ha = 1;
        end
        if (!rst) {pc, ir, acc, rd, wr} = '0;
        return {xs, ys, as, pc, ir, acc, rd, wr, fs, fe, ha};
    endfunction

    function automatic int next_ph(int ph, logic [3:0] f, logic rdy);
        if (ph == PH_FETCH) return rdy ? PH_EXEC : PH_FETCH;
        if (ph == PH_HALT)  return PH_HALT;
        if (f < 4)          return rdy ? PH_FETCH : PH_EXEC;
        if (f == 7)         return PH_HALT;
        return PH_FETCH;
    endfunction

    // One clock: advance the model on the edge, apply new inputs, check at negedge.
    task automatic cyc(input string tag, input logic [3:0] f, input logic n, input logic z,
                       input logic rdy, input logic rst);
        @(posedge Clk);
        if (Reset) m_ph = next_ph(m_ph, F, Ready);
        #1;
        F = f; N = n; Z = z; Ready = rdy; Reset = rst;
        if (!rst) m_ph = PH_FETCH;
        @(negedge Clk);
        chk(tag, obs, expect_out(m_ph, F, N, Z, Ready, Reset));
    endtask

    initial begin
        Reset = 1'b0; F = 4'h0; N = 1'b0; Z = 1'b0; Ready = 1'b1;
        m_ph = PH_FETCH;
        #2;
        chk("reset_state", obs, expect_out(PH_FETCH, F, N, Z, Ready, 1'b0));

        cyc("rst_hold",   4'h0, 0, 0, 1, 0);
        cyc("fetch_first", 4'h2, 0, 0, 1, 1);
        cyc("add_wait1",  4'h2, 0, 0, 0, 1);
        cyc("add_wait2",  4'h2, 0, 0, 0, 1);
        cyc("add_go",     4'h2, 0, 0, 1, 1);
        cyc("fetch_jge",  4'h5, 1, 0, 1, 1);
        cyc("jge_n1",     4'h5, 1, 0, 1, 1);
        cyc("fetch_jge",  4'h5, 0, 0, 1, 1);
        cyc("jge_n0",     4'h5, 0, 0, 1, 1);
        cyc("fetch_jne",  4'h6, 0, 1, 1, 1);
        cyc("jne_z1",     4'h6, 0, 1, 1, 1);
        cyc("fetch_jne",  4'h6, 0, 0, 1, 1);
        cyc("jne_z0",     4'h6, 0, 0, 1, 1);
        cyc("fetch_sta",  4'h1, 0, 0, 1, 1);
        cyc("sta",        4'h1, 0, 0, 1, 1);
        cyc("fetch_stp",  4'h7, 0, 0, 1, 1);
        cyc("stp",        4'h7, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++)
            cyc("halt_hold", 4'h0, i[0], i[1], i[0], 1);
        cyc("halt_reset", 4'h0, 0, 0, 1, 0);
        cyc("fetch_after_halt", 4'h0, 0, 0, 0, 1);
        cyc("fetch_wait", 4'h0, 0, 0, 0, 1);

        // Reset dropped mid-wait, away from any clock edge.
        #2;
        Reset = 1'b0;
        m_ph = PH_FETCH;
        #1;
        chk("rst_midwait", obs, expect_out(PH_FETCH, F, N, Z, Ready, 1'b0));
        cyc("midwait_release", 4'h0, 0, 0, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            cyc("random", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 31) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
